// File: rtl/univ_shift_reg_n_pkg.sv
// Shared mode encoding and helpers for the universal shift register.
package shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_LFSR = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

  // Modes that move bits through the register and therefore advance the word counter.
  function automatic logic is_shift(input mode_t mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
           (mode == MODE_ROR) || (mode == MODE_LFSR);
  endfunction

  // Modes that restart word capture.
  function automatic logic is_clear(input mode_t mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_n_if.sv
// Control/data bundle between the board-side driver and the shift register.
interface univ_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] q;
  logic             z;
  logic             match;
  logic [CNT_W-1:0] cnt;
  logic             word_done;

  modport master (
    output en, mode, sin_r, sin_l, pdata, pattern,
    input  q, z, match, cnt, word_done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pdata, pattern,
    output q, z, match, cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg_n_word_counter.sv
// Counts shift operations and pulses word_done for one cycle on every WIDTH-th shift.
module shift_word_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  // Next count and pulse; the pulse defaults low so it never lasts beyond one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Counter and pulse registers; reset drops any partial word silently.
  always_ff @(posedge cp) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt       = cnt_q;
  assign word_done = done_q;

endmodule

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register: shift, rotate, load, LFSR, clear,
// with XOR-tap output, pattern match and word-complete counter.
module univ_shift_reg_n
  import shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = {2'b11, {(WIDTH-2){1'b0}}}
) (
  input  logic                cp,
  input  logic                rst,
  univ_shift_reg_n_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] q_d, q_q;
  logic             fb;
  logic             inc;
  logic             clr;
  logic [CNT_W-1:0] cnt_w;
  logic             word_done_w;

  // Mode mux; en low holds the register.
  always_comb begin
    q_d = q_q;
    fb  = ^(q_q & TAPS);
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.sin_r};
        MODE_SHR:  q_d = {bus.sin_l, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = bus.pdata;
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        // All-zero is a fixed point of the XOR feedback, so kick it out to 1.
        MODE_LFSR: q_d = (q_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                     : {q_q[WIDTH-2:0], fb};
        MODE_CLR:  q_d = '0;
        default:   q_d = q_q;
      endcase
    end
  end

  // Data register.
  always_ff @(posedge cp) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  // Counter control decoded from the current mode.
  always_comb begin
    inc = is_shift(bus.mode);
    clr = is_clear(bus.mode);
  end

  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_word_counter (
    .cp        (cp),
    .rst       (rst),
    .en        (bus.en),
    .inc       (inc),
    .clr       (clr),
    .cnt       (cnt_w),
    .word_done (word_done_w)
  );

  assign bus.q         = q_q;
  assign bus.z         = ^(q_q & TAPS);
  assign bus.match     = (q_q == bus.pattern);
  assign bus.cnt       = cnt_w;
  assign bus.word_done = word_done_w;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n: three instances (3-bit, 8-bit default taps, 8-bit LFSR taps).
module tb_univ_shift_reg_n;
  import shift_pkg::*;

  logic cp = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 cp = ~cp;

  univ_shift_reg_n_if #(.WIDTH(3)) ia ();
  univ_shift_reg_n_if #(.WIDTH(8)) ib ();
  univ_shift_reg_n_if #(.WIDTH(8)) ic ();

  univ_shift_reg_n #(.WIDTH(3), .TAPS(3'b110)) dut_a (.cp(cp), .rst(rst), .bus(ia));
  univ_shift_reg_n #(.WIDTH(8))                dut_b (.cp(cp), .rst(rst), .bus(ib));
  univ_shift_reg_n #(.WIDTH(8), .TAPS(8'hB8))  dut_c (.cp(cp), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lq, lexp;
    logic       seen [256];
    int         steps, distinct, pulses, total;

    rst = 1'b1;
    ia.en = 0; ia.mode = MODE_HOLD; ia.sin_r = 0; ia.sin_l = 0; ia.pdata = '0; ia.pattern = '0;
    ib.en = 0; ib.mode = MODE_HOLD; ib.sin_r = 0; ib.sin_l = 0; ib.pdata = '0; ib.pattern = '0;
    ic.en = 0; ic.mode = MODE_HOLD; ic.sin_r = 0; ic.sin_l = 0; ic.pdata = '0; ic.pattern = '0;
    tick();
    rst = 1'b0;
    chk("rst_q_a",   ia.q, 0);
    chk("rst_cnt_a", ia.cnt, 0);
    chk("rst_wd_a",  ia.word_done, 0);
    chk("rst_q_b",   ib.q, 0);

    // 3-bit serial capture
    ia.en = 1; ia.mode = MODE_SHL;
    ia.sin_r = 1; tick();
    chk("t1_q1", ia.q, 3'b001); chk("t1_z1", ia.z, 0); chk("t1_c1", ia.cnt, 1); chk("t1_w1", ia.word_done, 0);
    ia.sin_r = 0; tick();
    chk("t1_q2", ia.q, 3'b010); chk("t1_z2", ia.z, 1); chk("t1_c2", ia.cnt, 2); chk("t1_w2", ia.word_done, 0);
    ia.sin_r = 1; tick();
    chk("t1_q3", ia.q, 3'b101); chk("t1_z3", ia.z, 1); chk("t1_c3", ia.cnt, 0); chk("t1_w3", ia.word_done, 1);
    ia.mode = MODE_HOLD; tick();
    chk("t1_w4", ia.word_done, 0); chk("t1_q4", ia.q, 3'b101);
    ia.en = 0;

    // 8-bit load / rotate / shift / match
    ib.pattern = 8'hA5; ib.en = 1; ib.mode = MODE_LOAD; ib.pdata = 8'hA5; tick();
    chk("t2_load_q", ib.q, 8'hA5); chk("t2_load_c", ib.cnt, 0); chk("t2_load_m", ib.match, 1); chk("t2_load_z", ib.z, 1);
    ib.mode = MODE_ROR; tick();
    chk("t2_ror_q", ib.q, 8'hD2); chk("t2_ror_m", ib.match, 0); chk("t2_ror_c", ib.cnt, 1);
    ib.mode = MODE_ROL; tick();
    chk("t2_rol_q", ib.q, 8'hA5); chk("t2_rol_m", ib.match, 1); chk("t2_rol_c", ib.cnt, 2);
    ib.mode = MODE_SHR; ib.sin_l = 0; tick();
    chk("t2_shr_q", ib.q, 8'h52); chk("t2_shr_m", ib.match, 0); chk("t2_shr_c", ib.cnt, 3);
    ib.mode = MODE_HOLD; ib.pattern = 8'h52; #1;
    chk("t2_pat_m", ib.match, 1);

    // Simultaneous events
    rst = 1; ib.en = 1; ib.mode = MODE_LOAD; ib.pdata = 8'hFF; tick();
    chk("t4_rst_q", ib.q, 0); chk("t4_rst_c", ib.cnt, 0); chk("t4_rst_w", ib.word_done, 0);
    rst = 0; ib.pdata = 8'h3C; tick();
    chk("t4_ld_q", ib.q, 8'h3C);
    ib.en = 0; ib.mode = MODE_SHL; ib.sin_r = 1; tick();
    chk("t4_en0_q", ib.q, 8'h3C); chk("t4_en0_c", ib.cnt, 0);
    ib.en = 1; ib.sin_r = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t4_wrap_w", ib.word_done, 1); chk("t4_wrap_c", ib.cnt, 0); chk("t4_wrap_q", ib.q, 0);
    ib.en = 0; tick();
    chk("t4_en0_w", ib.word_done, 0); chk("t4_en0_c2", ib.cnt, 0);
    tick();
    chk("t4_en0_w2", ib.word_done, 0);

    // Clear mid-word
    ib.en = 1; ib.mode = MODE_SHL; ib.sin_r = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_c5", ib.cnt, 5); chk("t5_q5", ib.q, 8'h1F);
    ib.mode = MODE_CLR; tick();
    chk("t5_clr_q", ib.q, 0); chk("t5_clr_c", ib.cnt, 0); chk("t5_clr_w", ib.word_done, 0);
    ib.mode = MODE_SHL; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_wd", ib.word_done, (i == 7) ? 1 : 0);
      if (ib.word_done) pulses++;
    end
    chk("t5_pulses", pulses, 1); chk("t5_q", ib.q, 8'hFF);
    ib.mode = MODE_HOLD; tick();
    chk("t5_wd_after", ib.word_done, 0);

    // Reset mid-word
    ib.mode = MODE_SHL;
    for (int i = 0; i < 7; i++) tick();
    chk("t6_c7", ib.cnt, 7);
    rst = 1; tick();
    chk("t6_rst_c", ib.cnt, 0); chk("t6_rst_w", ib.word_done, 0); chk("t6_rst_q", ib.q, 0);
    rst = 0; ib.mode = MODE_HOLD; tick();
    chk("t6_next_w", ib.word_done, 0); chk("t6_next_c", ib.cnt, 0);
    ib.mode = MODE_SHL; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_wd", ib.word_done, (i == 7) ? 1 : 0);
      if (ib.word_done) pulses++;
    end
    chk("t6_pulses", pulses, 1);
    ib.en = 0;

    // LFSR from zero with taps B8
    chk("t3_start_q", ic.q, 0); chk("t3_start_c", ic.cnt, 0);
    ic.en = 1; ic.mode = MODE_LFSR; tick();
    chk("t3_escape_q", ic.q, 8'h01); chk("t3_escape_c", ic.cnt, 1);
    foreach (seen[k]) seen[k] = 1'b0;
    seen[1] = 1'b1; distinct = 1; steps = 0; pulses = 0; total = 1; lq = 8'h01;
    while (steps < 300) begin
      lexp = {lq[6:0], ^(lq & 8'hB8)};
      tick();
      steps++; total++;
      chk("t3_step_q", ic.q, lexp);
      chk("t3_step_wd", ic.word_done, (total % 8 == 0) ? 1 : 0);
      if (ic.word_done) pulses++;
      lq = ic.q;
      if (lq == 8'h01) break;
      if (!seen[lq]) begin
        seen[lq] = 1'b1;
        distinct++;
      end
    end
    chk("t3_period", steps, 255);
    chk("t3_distinct", distinct, 255);
    chk("t3_pulses", pulses, 32);
    ic.en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
